alu_arbiter: RTL and testbench

- Shares a single combinational 8-bit `ALU` instance between `N_REQ` requesters.
- Each requester issues an operation through a valid/ready request channel and receives its result through a valid/ready response channel.
- The block arbitrates between requesters, registers the operands, drives the `ALU`, and returns `result` and `zero` to the granted requester.
- It sits between the core's execution clients and the shared `ALU`.

---
 rtl/alu_arb_pkg.sv | 12 +
 rtl/alu.sv | 24 ++
 rtl/alu_arb_pick.sv | 33 +++
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_arb_pkg;
  localparam int ALU_W = 8;

  typedef logic [2:0] alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;
endpackage

// File: rtl/alu.sv
// Shared combinational 8-bit ALU; zero flag reflects the result.
module alu (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [2:0] i_op,
  output logic [7:0] o_result,
  output logic       o_zero
);
  always_comb begin
    o_result = 8'h00;
    case (i_op)
      3'b000:  o_result = i_a + i_b;
      3'b001:  o_result = i_a - i_b;
      3'b010:  o_result = i_a & i_b;
      3'b011:  o_result = i_a | i_b;
      3'b100:  o_result = i_a ^ i_b;
      3'b101:  o_result = i_a << i_b[2:0];
      3'b110:  o_result = i_a >> i_b[2:0];
      default: o_result = i_a;
    endcase
  end

  assign o_zero = (o_result == 8'h00);
endmodule

// File: rtl/alu_arb_pick.sv
// Grant selection: round-robin from i_rr with ALU_ARB_RR_EN, else lowest index wins.
module alu_arb_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         i_valid,
`ifdef ALU_ARB_RR_EN
  input  logic [$clog2(N_REQ)-1:0] i_rr,
`endif
  output logic                     o_valid,
  output logic [$clog2(N_REQ)-1:0] o_idx
);
  localparam int IW = $clog2(N_REQ);

  always_comb begin
    int j;
    j       = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef ALU_ARB_RR_EN
      // Walk upward from the pointer, wrapping back to requester 0.
      j = int'(i_rr) + k;
      if (j >= N_REQ) j = j - N_REQ;
`else
      j = k;
`endif
      if (!o_valid && i_valid[j]) begin
        o_valid = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ valid/ready requesters, one operation in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = ALU_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  alu_op_t [N_REQ-1:0]            req_op,
  input  logic [N_REQ-1:0][W-1:0]        req_a,
  input  logic [N_REQ-1:0][W-1:0]        req_b,
  output logic [N_REQ-1:0]               rsp_valid,
  input  logic [N_REQ-1:0]               rsp_ready,
  output logic [W-1:0]                   rsp_result,
  output logic                           rsp_zero,
  output logic                           busy,
  output logic [$clog2(N_REQ)-1:0]       gnt_id
);
  localparam int IW = $clog2(N_REQ);

  arb_state_t      r_state, w_next;
  alu_op_t         r_op;
  logic [W-1:0]    r_a, r_b, r_result;
  logic            r_zero;
  logic [IW-1:0]   r_gnt;
  logic            w_pick_valid;
  logic [IW-1:0]   w_pick_idx;
  logic [W-1:0]    w_alu_result;
  logic            w_alu_zero;
  logic            w_rsp_hs;

`ifdef ALU_ARB_RR_EN
  logic [IW-1:0]   r_rr;
`endif

  alu_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .i_valid (req_valid),
`ifdef ALU_ARB_RR_EN
    .i_rr    (r_rr),
`endif
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  alu u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  assign w_rsp_hs = rsp_ready[r_gnt];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (w_rsp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_gnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      r_rr     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_pick_valid) begin
          r_op  <= req_op[w_pick_idx];
          r_a   <= req_a[w_pick_idx];
          r_b   <= req_b[w_pick_idx];
          r_gnt <= w_pick_idx;
        end
        EXEC: begin
          r_result <= w_alu_result;
          r_zero   <= w_alu_zero;
        end
        RESP: begin
`ifdef ALU_ARB_RR_EN
          if (w_rsp_hs) begin
            if (r_gnt == IW'(N_REQ - 1)) r_rr <= '0;
            else                         r_rr <= r_gnt + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are forced idle while reset is held so no transfer appears to complete.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    if (!rst) begin
      if (r_state == IDLE && w_pick_valid) req_ready[w_pick_idx] = 1'b1;
      if (r_state == RESP)                 rsp_valid[r_gnt]      = 1'b1;
      busy = (r_state != IDLE);
    end
  end

  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign gnt_id     = r_gnt;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (N_REQ=2); follows ALU_ARB_RR_EN if defined.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  alu_op_t [1:0]    req_op;
  logic [1:0][7:0]  req_a;
  logic [1:0][7:0]  req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_zero;
  logic             busy;
  logic [0:0]       gnt_id;

  int assertCount = 0;
  int failCount   = 0;

  alu_arbiter #(.N_REQ(2), .W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy),
    .gnt_id     (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input alu_op_t op, input logic [7:0] a, input logic [7:0] b);
    req_valid[idx] = 1'b1;
    req_op[idx]    = op;
    req_a[idx]     = a;
    req_b[idx]     = b;
    #1;
  endtask

  initial begin
    logic [1:0] expGnt [4];
    logic [7:0] expRes [4];
    int         g;

    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_gnt_id", gnt_id, 0);
    checkOutput("rst_result", rsp_result, 8'h00);
    checkOutput("rst_zero", rsp_zero, 0);

    // Single add on requester 0, operand changed after acceptance.
    $display("[TB] single add / operand stability");
    applyStimulus(0, 3'b000, 8'h0A, 8'h05);
    checkOutput("add_req_ready", req_ready, 2'b01);
    checkOutput("add_idle_busy", busy, 0);
    tick();
    req_valid = '0;
    req_a[0] = 8'hFF;
    rsp_ready = 2'b01;
    #1;
    checkOutput("add_exec_busy", busy, 1);
    checkOutput("add_exec_rsp_valid", rsp_valid, 0);
    checkOutput("add_exec_gnt", gnt_id, 0);
    tick();
    checkOutput("add_rsp_valid", rsp_valid, 2'b01);
    checkOutput("add_result", rsp_result, 8'h0F);
    checkOutput("add_zero", rsp_zero, 0);
    tick();
    checkOutput("add_done_busy", busy, 0);
    checkOutput("add_done_rsp_valid", rsp_valid, 0);

    // Zero flag via requester 1.
    $display("[TB] zero flag");
    rsp_ready = '0;
    applyStimulus(1, 3'b000, 8'h00, 8'h00);
    checkOutput("zero_req_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    rsp_ready = 2'b10;
    tick();
    checkOutput("zero_rsp_valid", rsp_valid, 2'b10);
    checkOutput("zero_result", rsp_result, 8'h00);
    checkOutput("zero_flag", rsp_zero, 1);
    checkOutput("zero_gnt", gnt_id, 1);
    tick();
    checkOutput("zero_done_busy", busy, 0);

    // Contention: both requesters held valid, responses consumed immediately.
    $display("[TB] contention");
`ifdef ALU_ARB_RR_EN
    expGnt = '{2'd0, 2'd1, 2'd0, 2'd1};
    expRes = '{8'h02, 8'h10, 8'h02, 8'h10};
`else
    expGnt = '{2'd0, 2'd0, 2'd0, 2'd0};
    expRes = '{8'h02, 8'h02, 8'h02, 8'h02};
`endif
    rsp_ready = 2'b11;
    applyStimulus(0, 3'b000, 8'h01, 8'h01);
    applyStimulus(1, 3'b001, 8'h20, 8'h10);
    for (int i = 0; i < 4; i++) begin
      g = int'(expGnt[i]);
      checkOutput($sformatf("cont%0d_req_ready", i), req_ready, 32'(1 << g));
      tick();
      checkOutput($sformatf("cont%0d_exec_ready", i), req_ready, 0);
      checkOutput($sformatf("cont%0d_gnt", i), gnt_id, g);
      tick();
      checkOutput($sformatf("cont%0d_rsp_valid", i), rsp_valid, 32'(1 << g));
      checkOutput($sformatf("cont%0d_result", i), rsp_result, expRes[i]);
      tick();
      checkOutput($sformatf("cont%0d_idle", i), busy, 0);
    end
    req_valid = '0;
    rsp_ready = '0;
    #1;

    // Response backpressure for 5 cycles while another request waits.
    $display("[TB] backpressure");
    applyStimulus(0, 3'b000, 8'h03, 8'h04);
    checkOutput("bp_req_ready", req_ready, 2'b01);
    tick();
    applyStimulus(1, 3'b000, 8'h11, 8'h22);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d_rsp_valid", i), rsp_valid, 2'b01);
      checkOutput($sformatf("bp%0d_result", i), rsp_result, 8'h07);
      checkOutput($sformatf("bp%0d_zero", i), rsp_zero, 0);
      checkOutput($sformatf("bp%0d_busy", i), busy, 1);
      checkOutput($sformatf("bp%0d_req_ready", i), req_ready, 0);
      tick();
    end
    rsp_ready = 2'b10;
    #1;
    checkOutput("bp_wrong_ready_ignored", rsp_valid, 2'b01);
    tick();
    checkOutput("bp_still_resp", rsp_valid, 2'b01);
    rsp_ready = 2'b01;
    tick();
    checkOutput("bp_done_busy", busy, 0);
`ifdef ALU_ARB_RR_EN
    checkOutput("bp_next_grant", req_ready, 2'b10);
`else
    checkOutput("bp_next_grant", req_ready, 2'b01);
`endif
    req_valid = '0;
    rsp_ready = '0;
    #1;

    // Reset during EXEC discards the operation.
    $display("[TB] reset mid-operation");
    applyStimulus(1, 3'b000, 8'h05, 8'h05);
    checkOutput("rm_req_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    checkOutput("rm_exec_gnt", gnt_id, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rm_busy", busy, 0);
    checkOutput("rm_rsp_valid", rsp_valid, 0);
    checkOutput("rm_gnt", gnt_id, 0);
    checkOutput("rm_result", rsp_result, 8'h00);
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rm%0d_no_rsp", i), rsp_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
